// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder
//   Memory-side responder for the single-cycle CPU. Serves instruction fetches
//   from an instruction word store and loads/stores from a data word store,
//   flags misaligned or out-of-range accesses, and accepts a streaming loader
//   that fills either store while in the LOAD state.
//
// Parameters
//   IMEM_AW  instruction store address width in words
//   DMEM_AW  data store address width in words
//
// Ports
//   clk, rst                      clock, synchronous active-low reset
//   inst_ren/inst_addr/inst_data  fetch request, byte address, registered word
//   mem_ren/mem_wen/mem_addr      data read/write request and byte address
//   mem_dout / mem_din            CPU write data / registered read data
//   load_en/load_sel/load_valid/load_data  loader session, target, strobe, word
//   busy, load_wrap               LOAD state flag, sticky pointer-wrap flag
//   inst_fault, mem_fault, fault_addr  last-access fault flags and address
//   stat_inst/stat_load/stat_store     saturating access counters
//
// Build option
//   MEM_STAT_EN  when defined the access counters are implemented; otherwise
//                the three counter outputs are tied to zero.

module cpu_mem_responder #(
  parameter int IMEM_AW = 6,
  parameter int DMEM_AW = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_ren,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_data,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  input  logic        load_en,
  input  logic        load_sel,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  output logic        busy,
  output logic        load_wrap,
  output logic        inst_fault,
  output logic        mem_fault,
  output logic [31:0] fault_addr,
  output logic [15:0] stat_inst,
  output logic [15:0] stat_load,
  output logic [15:0] stat_store
);

  localparam int PW = (IMEM_AW > DMEM_AW) ? IMEM_AW : DMEM_AW;
  localparam logic [PW-1:0] IMAX = PW'((2 ** IMEM_AW) - 1);
  localparam logic [PW-1:0] DMAX = PW'((2 ** DMEM_AW) - 1);

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [31:0] r_imem [2**IMEM_AW];
  logic [31:0] r_dmem [2**DMEM_AW];

  logic          r_sel;
  logic [PW-1:0] r_ptr;
  logic          r_wrap;
  logic [31:0]   r_inst_data;
  logic [31:0]   r_mem_din;
  logic          r_inst_fault;
  logic          r_mem_fault;
  logic [31:0]   r_fault_addr;

  logic               w_run;
  logic               w_entry;
  logic               w_load_wr;
  logic               w_ptr_last;
  logic               w_inst_bad;
  logic               w_mem_bad;
  logic               w_inst_acc;
  logic               w_inst_ok;
  logic               w_inst_flt;
  logic               w_mem_acc;
  logic               w_mem_flt;
  logic               w_rd_ok;
  logic               w_wr_ok;
  logic [IMEM_AW-1:0] w_iidx;
  logic [DMEM_AW-1:0] w_didx;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst) r_state <= RUN;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      RUN:     if (load_en)  w_next = LOAD;
      LOAD:    if (!load_en) w_next = RUN;
      default: w_next = RUN;
    endcase
  end

  // The entry edge (RUN with load_en high) only changes state, so CPU
  // servicing is restricted to RUN cycles with load_en low.
  assign w_run      = (r_state == RUN) && !load_en;
  assign w_entry    = (r_state == RUN) && load_en;
  assign w_load_wr  = (r_state == LOAD) && load_en && load_valid;
  assign w_ptr_last = r_sel ? (r_ptr == DMAX) : (r_ptr == IMAX);

  // ---------------------------------------------------------------- decode
  assign w_iidx     = inst_addr[IMEM_AW+1:2];
  assign w_didx     = mem_addr[DMEM_AW+1:2];
  assign w_inst_bad = (inst_addr[1:0] != 2'b00) || (|inst_addr[31:IMEM_AW+2]);
  assign w_mem_bad  = (mem_addr[1:0] != 2'b00) || (|mem_addr[31:DMEM_AW+2]);

  assign w_inst_acc = w_run && inst_ren;
  assign w_inst_ok  = w_inst_acc && !w_inst_bad;
  assign w_inst_flt = w_inst_acc && w_inst_bad;
  assign w_mem_acc  = w_run && (mem_ren || mem_wen);
  assign w_mem_flt  = w_mem_acc && w_mem_bad;
  assign w_rd_ok    = w_run && mem_ren && !w_mem_bad;
  assign w_wr_ok    = w_run && mem_wen && !w_mem_bad;

  // ---------------------------------------------------------------- stores
  // Stores have no reset; writes are blocked while reset is asserted so an
  // interrupted load keeps the words already written.
  always_ff @(posedge clk) begin
    if (rst && w_load_wr && !r_sel)
      r_imem[r_ptr[IMEM_AW-1:0]] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if (w_load_wr && r_sel)
        r_dmem[r_ptr[DMEM_AW-1:0]] <= load_data;
      else if (w_wr_ok)
        r_dmem[w_didx] <= mem_dout;
    end
  end

  // ---------------------------------------------------------------- control
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sel        <= 1'b0;
      r_ptr        <= '0;
      r_wrap       <= 1'b0;
      r_inst_data  <= '0;
      r_mem_din    <= '0;
      r_inst_fault <= 1'b0;
      r_mem_fault  <= 1'b0;
      r_fault_addr <= '0;
    end else begin
      if (w_entry) begin
        r_sel  <= load_sel;
        r_ptr  <= '0;
        r_wrap <= 1'b0;
      end
      if (w_load_wr) begin
        if (w_ptr_last) begin
          r_ptr  <= '0;
          r_wrap <= 1'b1;
        end else begin
          r_ptr <= r_ptr + 1'b1;
        end
      end
      if (r_state == LOAD) begin
        r_inst_data <= '0;
        r_mem_din   <= '0;
      end else begin
        if (w_inst_acc) begin
          r_inst_data  <= w_inst_ok ? r_imem[w_iidx] : '0;
          r_inst_fault <= w_inst_bad;
        end
        if (w_run && mem_ren)
          r_mem_din <= w_rd_ok ? r_dmem[w_didx] : '0;
        if (w_mem_acc)
          r_mem_fault <= w_mem_bad;
        if (w_mem_flt)
          r_fault_addr <= mem_addr;
        else if (w_inst_flt)
          r_fault_addr <= inst_addr;
      end
    end
  end

  assign inst_data  = r_inst_data;
  assign mem_din    = r_mem_din;
  assign busy       = (r_state == LOAD);
  assign load_wrap  = r_wrap;
  assign inst_fault = r_inst_fault;
  assign mem_fault  = r_mem_fault;
  assign fault_addr = r_fault_addr;

  // ---------------------------------------------------------------- counters
`ifdef MEM_STAT_EN
  logic [15:0] r_stat_inst;
  logic [15:0] r_stat_load;
  logic [15:0] r_stat_store;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stat_inst  <= '0;
      r_stat_load  <= '0;
      r_stat_store <= '0;
    end else begin
      if (w_inst_ok && (r_stat_inst != '1))  r_stat_inst  <= r_stat_inst + 16'd1;
      if (w_rd_ok   && (r_stat_load != '1))  r_stat_load  <= r_stat_load + 16'd1;
      if (w_wr_ok   && (r_stat_store != '1)) r_stat_store <= r_stat_store + 16'd1;
    end
  end

  assign stat_inst  = r_stat_inst;
  assign stat_load  = r_stat_load;
  assign stat_store = r_stat_store;
`else
  assign stat_inst  = '0;
  assign stat_load  = '0;
  assign stat_store = '0;
`endif

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Testbench for cpu_mem_responder: directed test-plan sequences, a table of
// data-port vectors with hand-computed expectations, and a randomized phase
// checked against an array-based behavioural model.

module tb_cpu_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_ren;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout;
  logic [31:0] mem_din;
  logic        load_en;
  logic        load_sel;
  logic        load_valid;
  logic [31:0] load_data;
  logic        busy;
  logic        load_wrap;
  logic        inst_fault;
  logic        mem_fault;
  logic [31:0] fault_addr;
  logic [15:0] stat_inst;
  logic [15:0] stat_load;
  logic [15:0] stat_store;

  cpu_mem_responder #(.IMEM_AW(6), .DMEM_AW(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_ren   (inst_ren),
    .inst_addr  (inst_addr),
    .inst_data  (inst_data),
    .mem_ren    (mem_ren),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_dout   (mem_dout),
    .mem_din    (mem_din),
    .load_en    (load_en),
    .load_sel   (load_sel),
    .load_valid (load_valid),
    .load_data  (load_data),
    .busy       (busy),
    .load_wrap  (load_wrap),
    .inst_fault (inst_fault),
    .mem_fault  (mem_fault),
    .fault_addr (fault_addr),
    .stat_inst  (stat_inst),
    .stat_load  (stat_load),
    .stat_store (stat_store)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------------------------------------------------------- model
  localparam int DEPTH = 64;
  logic [31:0] m_imem [DEPTH];
  logic [31:0] m_dmem [DEPTH];
  bit          m_ik   [DEPTH];
  bit          m_dk   [DEPTH];
  bit          m_load, m_sel, m_wrap, m_if, m_mf, m_idk, m_mdk;
  int          m_ptr;
  logic [31:0] m_id, m_md, m_fa;
  int          m_si, m_sl, m_ss;

  task automatic model_edge();
    int unsigned ia, ma;
    bit ibad, mbad;
    ia = inst_addr;
    ma = mem_addr;
    ibad = (ia % 4 != 0) || (ia >= 4 * DEPTH);
    mbad = (ma % 4 != 0) || (ma >= 4 * DEPTH);
    if (!rst) begin
      m_load = 0; m_sel = 0; m_ptr = 0; m_wrap = 0;
      m_id = 0; m_md = 0; m_idk = 1; m_mdk = 1;
      m_if = 0; m_mf = 0; m_fa = 0;
      m_si = 0; m_sl = 0; m_ss = 0;
    end else if (m_load) begin
      if (load_en && load_valid) begin
        if (m_sel) begin m_dmem[m_ptr] = load_data; m_dk[m_ptr] = 1; end
        else       begin m_imem[m_ptr] = load_data; m_ik[m_ptr] = 1; end
        m_ptr++;
        if (m_ptr == DEPTH) begin m_ptr = 0; m_wrap = 1; end
      end
      if (!load_en) m_load = 0;
      m_id = 0; m_md = 0; m_idk = 1; m_mdk = 1;
    end else if (load_en) begin
      m_load = 1; m_sel = load_sel; m_ptr = 0; m_wrap = 0;
    end else begin
      if (inst_ren) begin
        m_if = ibad;
        if (ibad) begin m_id = 0; m_idk = 1; end
        else begin
          m_id = m_imem[ia / 4]; m_idk = m_ik[ia / 4];
          if (m_si < 65535) m_si++;
        end
      end
      if (mem_ren) begin
        if (mbad) begin m_md = 0; m_mdk = 1; end
        else begin
          m_md = m_dmem[ma / 4]; m_mdk = m_dk[ma / 4];
          if (m_sl < 65535) m_sl++;
        end
      end
      if (mem_ren || mem_wen) m_mf = mbad;
      if (mem_wen && !mbad) begin
        m_dmem[ma / 4] = mem_dout; m_dk[ma / 4] = 1;
        if (m_ss < 65535) m_ss++;
      end
      if ((mem_ren || mem_wen) && mbad) m_fa = ma;
      else if (inst_ren && ibad)        m_fa = ia;
    end
  endtask

  // ---------------------------------------------------------------- helpers
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("busy", 32'(busy), 32'(m_load));
    chk("load_wrap", 32'(load_wrap), 32'(m_wrap));
    chk("inst_fault", 32'(inst_fault), 32'(m_if));
    chk("mem_fault", 32'(mem_fault), 32'(m_mf));
    chk("fault_addr", fault_addr, m_fa);
    if (m_idk) chk("inst_data", inst_data, m_id);
    if (m_mdk) chk("mem_din", mem_din, m_md);
`ifdef MEM_STAT_EN
    chk("stat_inst", 32'(stat_inst), 32'(m_si));
    chk("stat_load", 32'(stat_load), 32'(m_sl));
    chk("stat_store", 32'(stat_store), 32'(m_ss));
`else
    chk("stat_inst", 32'(stat_inst), 32'd0);
    chk("stat_load", 32'(stat_load), 32'd0);
    chk("stat_store", 32'(stat_store), 32'd0);
`endif
  endtask

  task automatic idle();
    inst_ren = 0; mem_ren = 0; mem_wen = 0; load_valid = 0;
  endtask

  task automatic fetch(input logic [31:0] a);
    idle(); inst_ren = 1; inst_addr = a; tick();
  endtask

  task automatic dread(input logic [31:0] a);
    idle(); mem_ren = 1; mem_addr = a; tick();
  endtask

  // ---------------------------------------------------------------- table
  typedef struct {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] dout;
    logic [31:0] exp_din;
    logic        exp_flt;
    logic [31:0] exp_fa;
  } dvec_t;

  dvec_t       tbl [12];
  logic [31:0] iw [37];
  logic [31:0] dw [65];
  logic [31:0] rw [3];

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 32'h08,       32'h12345678, 32'h00000000, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 32'h08,       32'h0,        32'h12345678, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b1, 32'h08,       32'hAAAA5555, 32'h12345678, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 1'b0, 32'h08,       32'h0,        32'hAAAA5555, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 1'b1, 32'h00,       32'h0BADF00D, 32'hAAAA5555, 1'b0, 32'h0};
    tbl[5]  = '{1'b1, 1'b0, 32'h0A,       32'h0,        32'h00000000, 1'b1, 32'h0A};
    tbl[6]  = '{1'b0, 1'b1, 32'h100,      32'hDEADBEEF, 32'h00000000, 1'b1, 32'h100};
    tbl[7]  = '{1'b1, 1'b0, 32'h00,       32'h0,        32'h0BADF00D, 1'b0, 32'h100};
    tbl[8]  = '{1'b0, 1'b1, 32'hFC,       32'h00000055, 32'h0BADF00D, 1'b0, 32'h100};
    tbl[9]  = '{1'b1, 1'b0, 32'hFC,       32'h0,        32'h00000055, 1'b0, 32'h100};
    tbl[10] = '{1'b1, 1'b0, 32'h104,      32'h0,        32'h00000000, 1'b1, 32'h104};
    tbl[11] = '{1'b1, 1'b0, 32'hFFFFFFFC, 32'h0,        32'h00000000, 1'b1, 32'hFFFFFFFC};

    // reset
    rst = 0; idle(); inst_addr = 0; mem_addr = 0; mem_dout = 0;
    load_en = 0; load_sel = 0; load_data = 0;
    tick(); tick();
    chk("rst inst_data", inst_data, 32'h0);
    chk("rst mem_din", mem_din, 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst load_wrap", 32'(load_wrap), 32'h0);
    chk("rst faults", {30'h0, inst_fault, mem_fault}, 32'h0);
    chk("rst fault_addr", fault_addr, 32'h0);
    chk("rst stats", {stat_inst, stat_load | stat_store}, 32'h0);
    rst = 1; tick();

    // load 37 words into the instruction store
    load_en = 1; load_sel = 0; tick();
    chk("entry busy", 32'(busy), 32'h1);
    for (int i = 0; i < 37; i++) begin
      iw[i] = $urandom; load_valid = 1; load_data = iw[i]; tick();
    end
    load_valid = 0; load_en = 0; tick();
    chk("exit busy", 32'(busy), 32'h0);
    chk("37 no wrap", 32'(load_wrap), 32'h0);

    fetch(32'h00); chk("fetch 0x00", inst_data, iw[0]);
    fetch(32'h04); chk("fetch 0x04", inst_data, iw[1]);
    fetch(32'h90); chk("fetch 0x90", inst_data, iw[36]);
    chk("fetch no fault", 32'(inst_fault), 32'h0);
    idle(); tick(); chk("fetch hold", inst_data, iw[36]);

    // data port table
    for (int i = 0; i < 12; i++) begin
      idle(); mem_ren = tbl[i].ren; mem_wen = tbl[i].wen;
      mem_addr = tbl[i].addr; mem_dout = tbl[i].dout; tick();
      chk($sformatf("tbl%0d mem_din", i), mem_din, tbl[i].exp_din);
      chk($sformatf("tbl%0d mem_fault", i), 32'(mem_fault), 32'(tbl[i].exp_flt));
      chk($sformatf("tbl%0d fault_addr", i), fault_addr, tbl[i].exp_fa);
    end

    // both faults in one cycle: data address wins
    idle(); inst_ren = 1; inst_addr = 32'h2; mem_ren = 1; mem_addr = 32'h101; tick();
    chk("dual inst_fault", 32'(inst_fault), 32'h1);
    chk("dual mem_fault", 32'(mem_fault), 32'h1);
    chk("dual fault_addr", fault_addr, 32'h101);
    chk("dual inst_data", inst_data, 32'h0);
    fetch(32'h300);
    chk("inst oor fault_addr", fault_addr, 32'h300);
    chk("inst oor mem_fault held", 32'(mem_fault), 32'h1);
    // fetch and store to different stores in the same cycle
    idle(); inst_ren = 1; inst_addr = 32'h08; mem_wen = 1; mem_addr = 32'h08; mem_dout = 32'h5A5A0001; tick();
    chk("parallel fetch", inst_data, iw[2]);
    dread(32'h08); chk("parallel store", mem_din, 32'h5A5A0001);
    check_all();

    // stream 65 words into the data store
    idle(); load_en = 1; load_sel = 1; tick();
    for (int i = 0; i < 65; i++) begin
      dw[i] = $urandom; load_valid = 1; load_data = dw[i]; tick();
      if (i == 62) chk("wrap before last", 32'(load_wrap), 32'h0);
      if (i == 63) chk("wrap at last", 32'(load_wrap), 32'h1);
    end
    chk("load inst_data zero", inst_data, 32'h0);
    load_en = 0; load_valid = 1; load_data = 32'hFFFF0000; tick();
    chk("wrap sticky", 32'(load_wrap), 32'h1);
    chk("wrap exit busy", 32'(busy), 32'h0);
    dread(32'h00); chk("word0 = 65th", mem_din, dw[64]);
    dread(32'h04); chk("exit valid ignored", mem_din, dw[1]);
    check_all();

    // reset in the middle of a load
    idle(); load_en = 1; load_sel = 1; tick();
    for (int i = 0; i < 3; i++) begin
      rw[i] = $urandom; load_valid = 1; load_data = rw[i]; tick();
    end
    rst = 0; load_en = 0; load_valid = 0; tick();
    chk("midload busy", 32'(busy), 32'h0);
    chk("midload wrap", 32'(load_wrap), 32'h0);
    rst = 1; tick();
    dread(32'h00); chk("kept word0", mem_din, rw[0]);
    dread(32'h04); chk("kept word1", mem_din, rw[1]);
    dread(32'h08); chk("kept word2", mem_din, rw[2]);
    dread(32'h0C); chk("untouched word3", mem_din, dw[3]);

    // counters: 5 fetches, 2 reads, 1 faulting write
    rst = 0; idle(); tick(); rst = 1;
    for (int i = 0; i < 5; i++) fetch(32'(i * 4));
    dread(32'h00); dread(32'h04);
    idle(); mem_wen = 1; mem_addr = 32'h101; mem_dout = 32'h1; tick();
`ifdef MEM_STAT_EN
    chk("stat_inst", 32'(stat_inst), 32'd5);
    chk("stat_load", 32'(stat_load), 32'd2);
`else
    chk("stat_inst", 32'(stat_inst), 32'd0);
    chk("stat_load", 32'(stat_load), 32'd0);
`endif
    chk("stat_store", 32'(stat_store), 32'd0);
    check_all();

    // randomized phase against the model
    idle();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) != 0);
      if (load_en) begin
        if ($urandom_range(0, 19) == 0) load_en = 0;
      end else if ($urandom_range(0, 29) == 0) begin
        load_en = 1; load_sel = 1'($urandom);
      end
      load_valid = 1'($urandom);
      load_data  = $urandom;
      inst_ren   = 1'($urandom);
      mem_ren    = 1'($urandom);
      mem_wen    = ($urandom_range(0, 2) == 0);
      mem_dout   = $urandom;
      for (int k = 0; k < 2; k++) begin
        logic [31:0] a;
        case ($urandom_range(0, 9))
          0:       a = 32'($urandom_range(0, 255)) | 32'h1;
          1:       a = $urandom & 32'hFFFFFFFC | 32'h100;
          default: a = 32'($urandom_range(0, 63)) << 2;
        endcase
        if (k == 0) inst_addr = a; else mem_addr = a;
      end
      tick();
      check_all();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_mem_responder.md
# cpu_mem_responder

Memory-side responder for the single-cycle CPU's instruction and data buses. It serves instruction fetches from an instruction word store and loads/stores from a data word store, and it flags misaligned or out-of-range accesses. A streaming loader port fills either store before or between runs. In the top level it sits opposite the CPU core and replaces the bench-side instruction array.

## Interface
Parameters:
- `IMEM_AW`, default 6: instruction store address width in words (64 words).
- `DMEM_AW`, default 6: data store address width in words (64 words).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `inst_ren`  in  1  CPU instruction read request.
- `inst_addr`  in  32  CPU instruction byte address.
- `inst_data`  out  32  fetched instruction word (registered).
- `mem_ren`  in  1  CPU data read request.
- `mem_wen`  in  1  CPU data write request.
- `mem_addr`  in  32  CPU data byte address.
- `mem_dout`  in  32  CPU write data.
- `mem_din`  out  32  read data returned to CPU (registered).
- `load_en`  in  1  loader session active.
- `load_sel`  in  1  loader target: 0 = instruction store, 1 = data store; sampled on entry to LOAD.
- `load_valid`  in  1  loader word strobe.
- `load_data`  in  32  loader word.
- `busy`  out  1  1 while in LOAD.
- `load_wrap`  out  1  loader pointer wrapped past the last word of the selected store (sticky).
- `inst_fault`  out  1  last fetch was misaligned or out of range.
- `mem_fault`  out  1  last data access was misaligned or out of range.
- `fault_addr`  out  32  byte address of the most recent faulting access.
- `stat_inst`, `stat_load`, `stat_store`  out  16 each  access counters (see Configuration).

## Operation
- State machine with two states, RUN and LOAD.
  - RUN → LOAD when `load_en`=1: latch `load_sel`, clear the pointer to 0, clear `load_wrap`.
  - LOAD → RUN when `load_en`=0.
- LOAD behaviour:
  - Each `load_valid` writes `load_data` to the selected store at the pointer, then increments the pointer.
  - When the pointer passes depth−1 it wraps to 0 and sets `load_wrap`, which stays set until the next LOAD entry or reset.
  - CPU requests are ignored: no store writes, `inst_data`/`mem_din` are driven to 0, no faults, no counting.
- Fetch in RUN with `inst_ren`=1:
  - Word index is `inst_addr[IMEM_AW+1:2]`.
  - Fault if `inst_addr[1:0]`≠0 or any bit of `inst_addr[31:IMEM_AW+2]` is set. On a fault, `inst_data` is 0, `inst_fault` is set and `fault_addr` is updated.
  - Otherwise `inst_data` is the stored word and `inst_fault` is cleared.
  - With `inst_ren`=0, `inst_data` holds its value.
- Data access in RUN: same alignment and range rules on `mem_addr` using `DMEM_AW`.
  - A faulting write is dropped.
  - A faulting read returns 0.
  - `mem_fault` is updated on every cycle with `mem_ren` or `mem_wen` asserted.
- Both faults in one cycle: `fault_addr` takes `mem_addr`.
- Store contents are not cleared by reset.

## Timing
- Reset values: state RUN, pointer 0, `inst_data`=0, `mem_din`=0, `busy`=0, `load_wrap`=0, both faults 0, `fault_addr`=0, all counters 0.
- Fetch latency is 1 cycle: the address presented before edge N gives `inst_data` valid after edge N.
- Read latency is 1 cycle, same as fetch.
- Writes commit at the edge where `mem_wen`=1.
- `mem_ren` and `mem_wen` to the same word in one cycle: read-before-write. `mem_din` returns the old word; the new word is visible from the next read.
- Fetch and store to different stores in the same cycle proceed independently.
- `load_en` rising: the entry edge only changes state; the first `load_valid` accepted is on the following edge. `busy` rises 1 cycle after `load_en`.
- `load_valid` on the exit edge (`load_en`=0) is ignored.
- Reset asserted mid-LOAD: return to RUN, pointer 0. Words already written are kept.

## Configuration
- `MEM_STAT_EN` defined: counters are active.
  - `stat_inst` counts accepted non-faulting fetches.
  - `stat_load` counts non-faulting reads.
  - `stat_store` counts non-faulting writes.
  - Counters increment in RUN only, saturate at 16'hFFFF and clear on reset.
- `MEM_STAT_EN` undefined: counter logic is absent and all three outputs are tied to 0.

## Test plan
- Load 37 words into the instruction store (`load_sel`=0), drop `load_en`, fetch addresses 0x00, 0x04, 0x90 → `inst_data` shows word 0, word 1 and word 36 one cycle later, with `inst_fault`=0.
- Store 0x12345678 to 0x08, then read 0x08 → `mem_din`=0x12345678. Simultaneous read and write of 0xAAAA5555 at 0x08 → read returns 0x12345678, the next read returns 0xAAAA5555.
- Read 0x0A (misaligned) and write to 0x100 (out of range, `DMEM_AW`=6) → `mem_fault`=1, `mem_din`=0, `fault_addr`=0x100 after the write, and 0x100's aliased word 0 is unchanged.
- Stream 65 words into the data store → `load_wrap`=1 and word 0 holds the 65th value.
- Assert `rst`=0 mid-LOAD after 3 words → `busy`=0 next cycle, and the 3 words are readable after RUN resumes.
- With `MEM_STAT_EN`: 5 fetches, 2 reads, 1 faulting write → `stat_inst`=5, `stat_load`=2, `stat_store`=0.
